// File: rtl/credit_rx_mem.sv
`default_nettype none
// ============================================================================
// Module   : credit_rx_mem
// Brief    : DEPTH x WIDTH register array, one write port, combinational read.
// Revision : 1.0
// ============================================================================
module credit_rx_mem #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    // Storage is deliberately left unreset; OutValid qualifies every read.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/credit_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : credit_rx_buffer
// Brief    : Receiver FIFO for a credit-based link; returns one credit per pop.
// Revision : 1.0
// ============================================================================
module credit_rx_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       InValid,
    input  logic [WIDTH-1:0]           InData,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [WIDTH-1:0]           OutData,
    output logic                       CreditReturn,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [AW-1:0] r_wrptr;
    logic [AW-1:0] r_rdptr;
    logic [CW-1:0] r_count;
    logic          r_credit;
    logic          r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push_acc;
    logic w_drop;

    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    assign w_pop      = ~w_empty & OutReady;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_push_acc = InValid & (~w_full | w_pop);
    assign w_drop     = InValid & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wrptr    <= '0;
            r_rdptr    <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (w_push_acc) begin
                r_wrptr <= r_wrptr + AW'(1);
            end
            if (w_pop) begin
                r_rdptr <= r_rdptr + AW'(1);
            end
            if (w_push_acc && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push_acc) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    credit_rx_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(AW)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_push_acc),
        .i_waddr(r_wrptr),
        .i_wdata(InData),
        .i_raddr(r_rdptr),
        .o_rdata(OutData)
    );

    assign OutValid     = ~w_empty;
    assign CreditReturn = r_credit;
    assign Count        = r_count;
    assign Overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_credit_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_credit_rx_buffer
// Brief    : Directed and randomized checks against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_credit_rx_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             resetn;
    logic             InValid;
    logic [WIDTH-1:0] InData;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] OutData;
    logic             CreditReturn;
    logic [2:0]       Count;
    logic             Overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue contents, sticky overflow, credit due this cycle.
    logic [WIDTH-1:0] q[$];
    logic             m_ovf;
    logic             m_credit;

    credit_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .InValid     (InValid),
        .InData      (InData),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .OutData     (OutData),
        .CreditReturn(CreditReturn),
        .Count       (Count),
        .Overflow    (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs at negedge, advance the model, settle past posedge.
    task automatic step(input logic rn, input logic iv, input logic [WIDTH-1:0] d,
                        input logic ordy);
        logic pop;
        @(negedge clk);
        resetn   = rn;
        InValid  = iv;
        InData   = d;
        OutReady = ordy;
        pop = 1'b0;
        if (!rn) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            pop = (q.size() > 0) && ordy;
            if (pop) void'(q.pop_front());
            if (iv) begin
                if (q.size() < DEPTH) q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_credit = pop;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", Count); end
        n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got %b want 0", OutValid); end
        n_checks++; if (CreditReturn !== 1'b0) begin n_fail++; $display("FAIL reset_credit got %b want 0", CreditReturn); end
        n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", Overflow); end
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        n_checks++;
        if (Count !== 3'd0 || OutValid !== 1'b0 || CreditReturn !== 1'b0 || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got cnt=%0d v=%b cr=%b ov=%b want 0 0 0 0",
                     Count, OutValid, CreditReturn, Overflow);
        end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] beats [4];
        beats = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, beats[i], 1'b0);
        n_checks++; if (Count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", Count); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (OutValid !== 1'b1 || OutData !== beats[i]) begin
                n_fail++; $display("FAIL drain_head[%0d] got v=%b d=%h want v=1 d=%h", i, OutValid, OutData, beats[i]);
            end
            step(1'b1, 1'b0, '0, 1'b1);
            n_checks++;
            if (CreditReturn !== 1'b1 || Count !== 3'(3 - i)) begin
                n_fail++; $display("FAIL drain_credit[%0d] got cr=%b cnt=%0d want cr=1 cnt=%0d", i, CreditReturn, Count, 3 - i);
            end
        end
        step(1'b1, 1'b0, '0, 1'b1);
        n_checks++;
        if (CreditReturn !== 1'b0 || OutValid !== 1'b0) begin
            n_fail++; $display("FAIL drain_done got cr=%b v=%b want 0 0", CreditReturn, OutValid);
        end
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, WIDTH'(8'h11 * (i + 1)), 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        n_checks++;
        if (Count !== 3'd4 || Overflow !== 1'b1 || CreditReturn !== 1'b0) begin
            n_fail++; $display("FAIL overflow_drop got cnt=%0d ov=%b cr=%b want 4 1 0", Count, Overflow, CreditReturn);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (OutData !== WIDTH'(8'h11 * (i + 1))) begin
                n_fail++; $display("FAIL overflow_drain[%0d] got %h want %h", i, OutData, WIDTH'(8'h11 * (i + 1)));
            end
            step(1'b1, 1'b0, '0, 1'b1);
        end
        n_checks++;
        if (OutValid !== 1'b0 || Overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_sticky got v=%b ov=%b want 0 1", OutValid, Overflow);
        end
    endtask

    task automatic test_full_pushpop();
        logic [WIDTH-1:0] heads [4];
        heads = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, WIDTH'(8'hA0 + i), 1'b0);
        n_checks++; if (OutData !== 8'hA0) begin n_fail++; $display("FAIL full_head got %h want a0", OutData); end
        step(1'b1, 1'b1, 8'hB0, 1'b1);
        n_checks++;
        if (Count !== 3'd4 || Overflow !== 1'b0 || CreditReturn !== 1'b1) begin
            n_fail++; $display("FAIL full_pushpop got cnt=%0d ov=%b cr=%b want 4 0 1", Count, Overflow, CreditReturn);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (OutData !== heads[i]) begin
                n_fail++; $display("FAIL full_order[%0d] got %h want %h", i, OutData, heads[i]);
            end
            step(1'b1, 1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            n_checks++;
            if (OutData !== WIDTH'(i - 1)) begin
                n_fail++; $display("FAIL wrap_head[%0d] got %h want %h", i, OutData, WIDTH'(i - 1));
            end
            step(1'b1, 1'b1, WIDTH'(i), 1'b1);
            n_checks++;
            if (Count !== 3'd1 || CreditReturn !== 1'b1) begin
                n_fail++; $display("FAIL wrap_flow[%0d] got cnt=%0d cr=%b want 1 1", i, Count, CreditReturn);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, WIDTH'(8'h60 + i), 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        n_checks++;
        if (Count !== 3'd0 || OutValid !== 1'b0 || CreditReturn !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid got cnt=%0d v=%b cr=%b want 0 0 0", Count, OutValid, CreditReturn);
        end
        step(1'b1, 1'b1, 8'h77, 1'b0);
        n_checks++;
        if (OutValid !== 1'b1 || OutData !== 8'h77 || Count !== 3'd1 || CreditReturn !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_push got v=%b d=%h cnt=%0d cr=%b want 1 77 1 0",
                               OutValid, OutData, Count, CreditReturn);
        end
    endtask

    task automatic test_random();
        logic rn, iv, ordy;
        step(1'b0, 1'b0, '0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            rn   = ($urandom_range(0, 63) != 0);
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 50);
            step(rn, iv, WIDTH'($urandom), ordy);
            n_checks++;
            if (Count !== 3'(q.size()) || OutValid !== (q.size() > 0)) begin
                n_fail++; $display("FAIL rand_occupancy[%0d] got cnt=%0d v=%b want cnt=%0d", c, Count, OutValid, q.size());
            end
            if (q.size() > 0) begin
                n_checks++;
                if (OutData !== q[0]) begin
                    n_fail++; $display("FAIL rand_head[%0d] got %h want %h", c, OutData, q[0]);
                end
            end
            n_checks++;
            if (CreditReturn !== m_credit || Overflow !== m_ovf) begin
                n_fail++; $display("FAIL rand_flags[%0d] got cr=%b ov=%b want cr=%b ov=%b",
                                   c, CreditReturn, Overflow, m_credit, m_ovf);
            end
        end
    endtask

    initial begin
        resetn   = 1'b0;
        InValid  = 1'b0;
        InData   = '0;
        OutReady = 1'b0;
        m_ovf    = 1'b0;
        m_credit = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_pushpop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
